// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one bus request at a time and presents the response to decode.
// Supports stalls (instruction held), flushes, and redirects, including redirects during an outstanding request.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        flushF,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr,
    output logic        busy
);

    typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pending_q, pending_d;
    logic [31:0] hold_q, hold_d;
    logic [63:0] redirect_tgt;
    logic [63:0] pc_plus4;
    logic        unused_redirect_lsbs;

    // Instructions are word aligned, so the low two bits of a target are dropped.
    assign redirect_tgt         = {redirect_pc[63:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign pc_plus4             = pc_q + 64'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= 64'h0000_0000_8000_0000;
            pending_q <= 64'd0;
            hold_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        hold_d     = hold_q;
        ireq_valid = 1'b0;
        ireq_addr  = pc_q;
        f_valid    = 1'b0;
        f_pc       = pc_q;
        f_instr    = iresp_data;

        unique case (state_q)
            StFetch: begin
                ireq_valid = 1'b1;
                if (redirect_valid) begin
                    if (iresp_data_ok) begin
                        pc_d = redirect_tgt;
                    end else begin
                        // Request already on the bus: wait out its response before refetching.
                        pending_d = redirect_tgt;
                        state_d   = StDiscard;
                    end
                end else if (iresp_data_ok && !flushF) begin
                    f_valid = 1'b1;
                    if (stallF) begin
                        hold_d  = iresp_data;
                        state_d = StHold;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            StHold: begin
                f_instr = hold_q;
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = StFetch;
                end else if (!flushF) begin
                    f_valid = 1'b1;
                    if (!stallF) begin
                        pc_d    = pc_plus4;
                        state_d = StFetch;
                    end
                end
            end
            StDiscard: begin
                ireq_valid = 1'b1;
                if (redirect_valid) begin
                    pending_d = redirect_tgt;
                    if (iresp_data_ok) begin
                        pc_d    = redirect_tgt;
                        state_d = StFetch;
                    end
                end else if (iresp_data_ok) begin
                    pc_d    = pending_q;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (reset) begin
            ireq_valid = 1'b0;
            f_valid    = 1'b0;
        end
    end

    assign busy = ireq_valid & ~iresp_data_ok;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// all compared against a flag-based behavioural model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stallF, flushF, redirect_valid, iresp_data_ok;
    logic [63:0] redirect_pc;
    logic [31:0] iresp_data;
    logic        ireq_valid, f_valid, busy;
    logic [63:0] ireq_addr, f_pc;
    logic [31:0] f_instr;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: pc, a held instruction (if any) and a stale outstanding request.
    logic [63:0] m_pc;
    logic [63:0] m_target;
    logic [31:0] m_held;
    bit          m_holding;
    bit          m_stale;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stallF         (stallF),
        .flushF         (flushF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_instr        (f_instr),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs mid-period and compare outputs to the model.
    task automatic apply(input logic r, input logic st, input logic fl, input logic rv,
                         input logic [63:0] rp, input logic ok, input logic [31:0] d);
        logic        e_req, e_fv;
        logic [31:0] e_instr;
        @(negedge clk);
        reset = r; stallF = st; flushF = fl; redirect_valid = rv;
        redirect_pc = rp; iresp_data_ok = ok; iresp_data = d;
        #1;
        e_req   = !r && !m_holding;
        e_fv    = !r && !rv && !fl && (m_holding || (!m_stale && ok));
        e_instr = m_holding ? m_held : d;
        check("ireq_valid", {63'd0, ireq_valid}, {63'd0, e_req});
        check("busy", {63'd0, busy}, {63'd0, e_req && !ok});
        check("f_valid", {63'd0, f_valid}, {63'd0, e_fv});
        if (e_req) check("ireq_addr", ireq_addr, m_pc);
        if (e_fv) begin
            check("f_pc", f_pc, m_pc);
            check("f_instr", {32'd0, f_instr}, {32'd0, e_instr});
        end
    endtask

    // Advance the model by the cycle just applied.
    task automatic commit();
        logic [63:0] tgt;
        tgt = redirect_pc & ~64'h3;
        if (reset) begin
            m_pc = 64'h8000_0000; m_holding = 0; m_stale = 0; m_held = 0;
        end else if (m_holding) begin
            if (redirect_valid) begin
                m_pc = tgt; m_holding = 0;
            end else if (!flushF && !stallF) begin
                m_pc = m_pc + 4; m_holding = 0;
            end
        end else if (redirect_valid) begin
            if (iresp_data_ok) begin
                m_pc = tgt; m_stale = 0;
            end else begin
                m_stale = 1; m_target = tgt;
            end
        end else if (iresp_data_ok) begin
            if (m_stale) begin
                m_pc = m_target; m_stale = 0;
            end else if (!flushF) begin
                if (stallF) begin
                    m_holding = 1; m_held = iresp_data;
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end
    endtask

    initial begin
        m_pc = 0; m_target = 0; m_held = 0; m_holding = 0; m_stale = 0;
        reset = 1; stallF = 0; flushF = 0; redirect_valid = 0;
        redirect_pc = 0; iresp_data_ok = 0; iresp_data = 0;

        // Reset: outputs quiet even if the bus claims data.
        apply(1, 0, 0, 0, 0, 1, 32'h1111_1111);
        check("reset_ireq", {63'd0, ireq_valid}, 64'd0);
        commit();
        apply(1, 0, 0, 0, 0, 0, 0); commit();

        // Zero-wait streaming.
        apply(0, 0, 0, 0, 0, 1, 32'hA000_0000);
        check("stream0_pc", f_pc, 64'h8000_0000); commit();
        apply(0, 0, 0, 0, 0, 1, 32'hA000_0004);
        check("stream1_pc", f_pc, 64'h8000_0004); commit();
        apply(0, 0, 0, 0, 0, 1, 32'hA000_0008);
        check("stream2_pc", f_pc, 64'h8000_0008); commit();

        // Stall holds the instruction for four cycles, no requests while held.
        apply(1, 0, 0, 0, 0, 0, 0); commit();
        apply(0, 1, 0, 0, 0, 1, 32'hBEEF_0001);
        check("hold_first", {32'd0, f_instr}, 64'hBEEF_0001); commit();
        apply(0, 1, 0, 0, 0, 0, 32'h0);
        check("hold_noreq", {63'd0, ireq_valid}, 64'd0); commit();
        apply(0, 1, 0, 0, 0, 1, 32'h5555_5555);
        check("hold_instr", {32'd0, f_instr}, 64'hBEEF_0001); commit();
        apply(0, 0, 0, 0, 0, 0, 32'h0); commit();
        apply(0, 0, 0, 0, 0, 0, 32'h0);
        check("after_hold_addr", ireq_addr, 64'h8000_0004); commit();

        // Advance to 0x8000_0010, then redirect under a two-cycle bus latency.
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 1, $urandom); commit();
        end
        apply(0, 0, 0, 1, 64'h8000_0100, 0, 0);
        check("discard_addr0", ireq_addr, 64'h8000_0010); commit();
        apply(0, 0, 0, 0, 0, 0, 0);
        check("discard_addr1", ireq_addr, 64'h8000_0010); commit();
        apply(0, 0, 0, 0, 0, 1, 32'hDEAD_DEAD);
        check("discard_drop", {63'd0, f_valid}, 64'd0); commit();
        apply(0, 0, 0, 0, 0, 0, 0);
        check("redirect_addr", ireq_addr, 64'h8000_0100); commit();

        // Two redirects while discarding: the later one wins.
        apply(0, 0, 0, 1, 64'h8000_0200, 0, 0); commit();
        apply(0, 0, 0, 1, 64'h8000_0300, 0, 0); commit();
        apply(0, 0, 0, 0, 0, 1, 32'h1234_5678); commit();
        apply(0, 0, 0, 0, 0, 0, 0);
        check("latest_redirect", ireq_addr, 64'h8000_0300); commit();

        // Redirect with data_ok and stall: no hold, straight to target (low bits ignored).
        apply(0, 1, 0, 1, 64'h8000_0403, 1, 32'hCAFE_CAFE);
        check("redir_stall_fv", {63'd0, f_valid}, 64'd0); commit();
        apply(0, 1, 0, 0, 0, 0, 0);
        check("redir_stall_addr", ireq_addr, 64'h8000_0400); commit();

        // Reset while holding at 0x8000_0040; first post-reset data_ok is accepted.
        apply(0, 0, 0, 1, 64'h8000_0040, 1, 0); commit();
        apply(0, 1, 0, 0, 0, 1, 32'h0404_0404); commit();
        apply(1, 1, 0, 0, 0, 0, 0);
        check("reset_hold_fv", {63'd0, f_valid}, 64'd0); commit();
        apply(1, 0, 0, 0, 0, 1, 0); commit();
        apply(0, 0, 0, 0, 0, 1, 32'h7777_0000);
        check("post_reset_addr", ireq_addr, 64'h8000_0000);
        check("post_reset_fv", {63'd0, f_valid}, 64'd1); commit();

        // Flush in the response cycle refetches the same pc.
        apply(0, 0, 1, 0, 0, 1, 32'h0F0F_0F0F); commit();
        apply(0, 0, 0, 0, 0, 0, 0);
        check("flush_refetch", ireq_addr, 64'h8000_0004); commit();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            apply(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                  {$urandom, $urandom}, ($urandom_range(1) == 1), $urandom);
            commit();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: stallF  in  1  from hazard unit; fetched instruction not consumed this cycle.
REQ-004 SHALL have: flushF  in  1  from hazard unit; instruction presented this cycle is killed.
REQ-005 SHALL have: redirect_valid  in  1  resolved branch/jump; redirect_pc  in  64  its target.
REQ-006 SHALL have: ireq_valid  out  1  and ireq_addr  out  64  instruction-bus request.
REQ-007 SHALL have: iresp_data_ok  in  1  and iresp_data  in  32  instruction-bus response.
REQ-008 SHALL have: f_valid  out  1, f_pc  out  64, f_instr  out  32  to decode register; busy  out  1  fetch outstanding.

Function
REQ-009 SHALL keep a 64-bit pc, with bits [1:0] always 0 (redirect_pc[1:0] ignored); pc+4 wraps modulo 2^64.
REQ-010 SHALL implement FSM states FETCH, HOLD, DISCARD; plus a 64-bit pending_pc and 32-bit hold_instr register.
REQ-011 FETCH: ireq_valid=1, ireq_addr=pc; address SHALL stay stable until iresp_data_ok.
REQ-012 FETCH, data_ok, no redirect, !flushF, !stallF: f_valid=1 combinationally, f_pc=pc, f_instr=iresp_data; pc<=pc+4; stay FETCH (new request next cycle).
REQ-013 FETCH, data_ok, no redirect, !flushF, stallF: f_valid=1 that cycle; hold_instr<=iresp_data; go HOLD; pc unchanged.
REQ-014 HOLD: ireq_valid=0; f_valid=1, f_pc=pc, f_instr=hold_instr every cycle; on first cycle with !stallF and no redirect: pc<=pc+4, go FETCH.
REQ-015 FETCH, data_ok, flushF, no redirect: f_valid=0, data dropped, pc unchanged, stay FETCH (same pc refetched).
REQ-016 HOLD, flushF, no redirect: f_valid=0 that cycle; state unchanged.
REQ-017 Redirect in FETCH with data_ok same cycle: data dropped, f_valid=0, pc<=redirect_pc, stay FETCH.
REQ-018 Redirect in FETCH without data_ok: pending_pc<=redirect_pc, go DISCARD.
REQ-019 DISCARD: ireq_valid=1, ireq_addr=pc (old address held); f_valid=0; on data_ok data dropped, pc<=pending_pc, go FETCH.
REQ-020 Redirect in DISCARD: pending_pc<=redirect_pc (latest wins); if data_ok same cycle, pc<=redirect_pc directly, go FETCH.
REQ-021 Redirect in HOLD: held instruction dropped, f_valid=0, pc<=redirect_pc, go FETCH; redirect SHALL have priority over stallF in all states.
REQ-022 busy SHALL equal ireq_valid & !iresp_data_ok.
REQ-023 iresp_data_ok outside FETCH/DISCARD SHALL be ignored.
REQ-024 Minimum fetch throughput SHALL be one instruction per cycle when data_ok returns in the request cycle.

Reset
REQ-025 While reset=1: state<=FETCH, pc<=64'h8000_0000, pending_pc<=0, hold_instr<=0.
REQ-026 During reset cycles outputs SHALL be ireq_valid=0, f_valid=0, busy=0; first request issued cycle after reset deasserts.
REQ-027 Reset mid-operation SHALL abandon any outstanding request; a data_ok arriving in the first post-reset cycle SHALL be accepted as the 0x8000_0000 response.

Verification
REQ-028 Zero-wait bus, data_ok every cycle, no stall: f_pc sequence 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, f_valid=1 each.
REQ-029 data_ok at pc 8000_0000 with stallF=1 for 3 cycles: f_valid=1, f_instr held 4 cycles, ireq_valid=0 during HOLD, next ireq_addr 8000_0004.
REQ-030 Request at 8000_0010, 2-cycle bus latency, redirect_pc=8000_0100 in first cycle: ireq_addr stays 8000_0010 until data_ok, data dropped, next ireq_addr 8000_0100.
REQ-031 Two redirects (8000_0200 then 8000_0300) while in DISCARD: post-data_ok ireq_addr = 8000_0300.
REQ-032 Redirect coincident with data_ok and stallF=1: f_valid=0, next cycle ireq_addr=redirect_pc, no HOLD entry.
REQ-033 Reset asserted in HOLD at pc 8000_0040: next post-reset ireq_addr = 8000_0000, f_valid=0 throughout reset.
